fgpio_in_cond: RTL and testbench
================================

// Module: fgpio_in_cond
// PURPOSE
//  Input conditioning stage directly upstream of the FGPIO custom-instruction unit.
//  Takes raw pad inputs, synchronises them, glitch-filters each pin and drives the
//  FGPIO gpio_in_val bus. Also detects filtered edges on input-direction pins,
//  holds them as sticky per-pin flags and raises a level interrupt to the core.
// PARAMETERS
//  NUM        SOPHON_PKG::FGPIO_NUM          number of GPIO pins
//  SYNC_STG   SOPHON_PKG::FGPIO_SYNC_STAGES  synchroniser depth, default 2, min 2
//  FILT_W     SOPHON_PKG::FGPIO_FILT_W       filter counter width, default 4
// PORTS
//  clk_i         in   1       clock, same domain as FGPIO
//  rst_i         in   1       synchronous reset, active-high
//  pad_in_i      in   NUM     raw asynchronous pad inputs
//  gpio_dir_i    in   NUM     pin direction from FGPIO gpio_dir (1 = output)
//  filt_thr_i    in   FILT_W  glitch-filter threshold, shared by all pins
//  rise_en_i     in   NUM     per-pin rising-edge event enable
//  fall_en_i     in   NUM     per-pin falling-edge event enable
//  evt_clr_i     in   NUM     per-pin write-1-to-clear for both event flags (1-cycle pulse)
//  gpio_in_val_o out  NUM     filtered pin level -> FGPIO gpio_in_val
//  rise_pend_o   out  NUM     sticky rising-edge flags
//  fall_pend_o   out  NUM     sticky falling-edge flags
//  irq_o         out  1       |(rise_pend_o | fall_pend_o)
// BEHAVIOUR
//  Reset (rst_i=1 at a clk_i edge): sync flops, filter counters, gpio_in_val_o,
//   rise_pend_o, fall_pend_o all 0; irq_o = 0. Reset mid-filter discards the count.
//  Sync: SYNC_STG-flop chain per pin; s[i] = last stage. No other logic on pad_in_i.
//  Filter, per pin, state q[i] (= gpio_in_val_o[i]) and cnt[i] (FILT_W bits):
//   - s[i] == q[i]                          : cnt <= 0, q holds.
//   - s[i] != q[i] and cnt >= filt_thr_i     : q <= s[i], cnt <= 0.
//   - s[i] != q[i] and cnt <  filt_thr_i     : cnt <= cnt + 1.
//   - A level must differ from q for filt_thr_i+1 consecutive cycles to be accepted;
//     any single-cycle return to q restarts the count.
//   - filt_thr_i = 0: filter transparent, 1 cycle.
//   - Pad-to-gpio_in_val_o latency = SYNC_STG + filt_thr_i + 1 cycles.
//   - cnt never exceeds filt_thr_i, so there is no wrap. If filt_thr_i is lowered
//     below a running cnt, the >= compare accepts on the next differing cycle.
//  Filtering runs on every pin regardless of direction (output readback).
//  Edges: rise[i] = accept & s[i]; fall[i] = accept & ~s[i], in the cycle q updates.
//  Event set: rise_pend[i] <= 1 when rise[i] & rise_en_i[i] & ~gpio_dir_i[i]
//   (fall likewise). Output-direction pins never set flags. Enables gate new
//   events only; clearing an enable does not clear pending flags.
//  Event clear: evt_clr_i[i] clears both rise_pend[i] and fall_pend[i].
//   Set and clear in the same cycle: set wins, flag stays 1.
//  irq_o: combinational OR of registered flags; high the cycle after the edge is
//   accepted, low the cycle after the last flag is cleared.
//  Pending flags are registered. gpio_in_val_o is the registered q, with no
//   combinational path from pad_in_i.
// STRUCTURE
//  SOPHON_PKG adds FGPIO_SYNC_STAGES (2) and FGPIO_FILT_W (4) beside FGPIO_NUM.
//  Sub-module fgpio_pin_filter (one pin): sync chain, cnt, q, rise/fall pulses.
//   Instantiated NUM times in a generate loop.
//  Top level holds the pending-flag registers, the enable/dir gating and the irq OR.
// TESTING
//  1 Reset: hold rst_i 3 cycles with pad_in_i='1 -> all outputs 0. After release,
//    filt_thr_i=0: gpio_in_val_o='1 exactly 3 cycles later (SYNC_STG=2).
//  2 Glitch: filt_thr_i=3, pin0 high for 3 cycles then low -> gpio_in_val_o[0]
//    stays 0 and no event. Pin0 high for 4 cycles -> rises at cycle 2+3+1=6.
//  3 Events: rise_en_i=16'h0001, fall_en_i=0, pin0 0->1->0 with filt_thr_i=0 ->
//    rise_pend_o=1 and irq_o=1 one cycle after accept; fall_pend_o stays 0.
//  4 Direction mask: gpio_dir_i[1]=1, rise_en_i[1]=1, pin1 toggles ->
//    gpio_in_val_o[1] follows the pin; rise_pend_o[1]=0; irq_o=0.
//  5 Clear collision: evt_clr_i[0] pulsed in the same cycle as a new pin0 rise
//    accept -> rise_pend_o[0] stays 1. Second evt_clr_i pulse -> 0, irq_o drops next cycle.
//  6 Threshold change: filt_thr_i=7, pin differs 5 cycles, then filt_thr_i set to 2
//    -> accepted on the next differing cycle; no counter wrap.

Source files
------------

// File: rtl/fgpio_in_cond_pkg.sv
// Shared sizing constants for the FGPIO input-conditioning slice.
// Sync depth must stay >= 2 so the first flop can settle a metastable pad.
package fgpio_in_cond_pkg;
    localparam int FGPIO_NUM         = 16;
    localparam int FGPIO_SYNC_STAGES = 2;
    localparam int FGPIO_FILT_W      = 4;
endpackage

// File: rtl/fgpio_in_cond_if.sv
// Bus between the core-side GPIO block and the input-conditioning stage.
// The master drives pads and controls; the slave returns the conditioned levels and flags.
interface fgpio_in_cond_if
    import fgpio_in_cond_pkg::*;
#(
    parameter int NUM    = FGPIO_NUM,
    parameter int FILT_W = FGPIO_FILT_W
);
    logic [NUM-1:0]    pad_in_i;
    logic [NUM-1:0]    gpio_dir_i;
    logic [FILT_W-1:0] filt_thr_i;
    logic [NUM-1:0]    rise_en_i;
    logic [NUM-1:0]    fall_en_i;
    logic [NUM-1:0]    evt_clr_i;
    logic [NUM-1:0]    gpio_in_val_o;
    logic [NUM-1:0]    rise_pend_o;
    logic [NUM-1:0]    fall_pend_o;
    logic              irq_o;

    modport master (
        output pad_in_i, gpio_dir_i, filt_thr_i, rise_en_i, fall_en_i, evt_clr_i,
        input  gpio_in_val_o, rise_pend_o, fall_pend_o, irq_o
    );

    modport slave (
        input  pad_in_i, gpio_dir_i, filt_thr_i, rise_en_i, fall_en_i, evt_clr_i,
        output gpio_in_val_o, rise_pend_o, fall_pend_o, irq_o
    );
endinterface

// File: rtl/fgpio_pin_filter.sv
// One pin: synchroniser chain, glitch filter, and accept-cycle rise/fall pulses.
// A new level is taken once it has differed from the held level for filt_thr+1 cycles.
module fgpio_pin_filter #(
    parameter int SYNC_STG = 2,
    parameter int FILT_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pad,
    input  logic [FILT_W-1:0] filt_thr,
    output logic              level,
    output logic              rise,
    output logic              fall
);
    logic [SYNC_STG-1:0] sync_reg;
    logic                q_reg;
    logic [FILT_W-1:0]   cnt_reg;
    logic                s;
    logic                differ;
    logic                accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STG-2:0], pad};
        end
    end

    assign s      = sync_reg[SYNC_STG-1];
    assign differ = s ^ q_reg;
    // >= rather than == so a threshold lowered under a running count still accepts
    assign accept = differ && (cnt_reg >= filt_thr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_reg   <= 1'b0;
            cnt_reg <= '0;
        end else if (!differ) begin
            cnt_reg <= '0;
        end else if (accept) begin
            q_reg   <= s;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + FILT_W'(1);
        end
    end

    assign level = q_reg;
    assign rise  = accept & s;
    assign fall  = accept & ~s;
endmodule

// File: rtl/fgpio_in_cond.sv
// Input conditioning ahead of FGPIO: per-pin filters, sticky edge flags and a level irq.
// Output-direction pins are still filtered for readback but never raise events.
module fgpio_in_cond
    import fgpio_in_cond_pkg::*;
#(
    parameter int NUM      = FGPIO_NUM,
    parameter int SYNC_STG = FGPIO_SYNC_STAGES,
    parameter int FILT_W   = FGPIO_FILT_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fgpio_in_cond_if.slave  bus
);
    logic [NUM-1:0] level;
    logic [NUM-1:0] rise_evt;
    logic [NUM-1:0] fall_evt;
    logic [NUM-1:0] rise_pend_reg;
    logic [NUM-1:0] fall_pend_reg;
    logic [NUM-1:0] rise_pend_next;
    logic [NUM-1:0] fall_pend_next;

    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_pin
            fgpio_pin_filter #(
                .SYNC_STG (SYNC_STG),
                .FILT_W   (FILT_W)
            ) u_filt (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .pad      (bus.pad_in_i[gi]),
                .filt_thr (bus.filt_thr_i),
                .level    (level[gi]),
                .rise     (rise_evt[gi]),
                .fall     (fall_evt[gi])
            );
        end
    endgenerate

    // Clear is applied first so a simultaneous new event keeps the flag set
    always_comb begin
        rise_pend_next = (rise_pend_reg & ~bus.evt_clr_i)
                       | (rise_evt & bus.rise_en_i & ~bus.gpio_dir_i);
        fall_pend_next = (fall_pend_reg & ~bus.evt_clr_i)
                       | (fall_evt & bus.fall_en_i & ~bus.gpio_dir_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_pend_reg <= '0;
            fall_pend_reg <= '0;
        end else begin
            rise_pend_reg <= rise_pend_next;
            fall_pend_reg <= fall_pend_next;
        end
    end

    assign bus.gpio_in_val_o = level;
    assign bus.rise_pend_o   = rise_pend_reg;
    assign bus.fall_pend_o   = fall_pend_reg;
    assign bus.irq_o         = |(rise_pend_reg | fall_pend_reg);
endmodule

// File: tb/tb_fgpio_in_cond.sv
// Directed bench for fgpio_in_cond: a cycle model built from delay/run-length rules is
// compared every clock, and literal expectations pin latency, glitch, mask and clear cases.
module tb_fgpio_in_cond;
    import fgpio_in_cond_pkg::*;

    localparam int NUM      = FGPIO_NUM;
    localparam int SYNC_STG = FGPIO_SYNC_STAGES;
    localparam int FILT_W   = FGPIO_FILT_W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fgpio_in_cond_if #(.NUM(NUM), .FILT_W(FILT_W)) bus ();

    fgpio_in_cond #(
        .NUM      (NUM),
        .SYNC_STG (SYNC_STG),
        .FILT_W   (FILT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pad delayed by SYNC_STG edges, a level is taken after it has
    // been different for more than filt_thr consecutive cycles; flags are sticky.
    logic [NUM-1:0] hist[$];
    logic [NUM-1:0] m_val, m_rise, m_fall, m_s, m_acc;
    int             run[NUM];

    always @(posedge clk) begin
        if (rst) begin
            hist = {};
            for (int k = 0; k < SYNC_STG; k++) hist.push_front('0);
            m_val = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NUM; i++) run[i] = 0;
        end else begin
            m_s = hist[SYNC_STG-1];
            hist.push_front(bus.pad_in_i);
            void'(hist.pop_back());
            m_acc = '0;
            for (int i = 0; i < NUM; i++) begin
                if (m_s[i] != m_val[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] > int'(bus.filt_thr_i)) begin
                        m_acc[i] = 1'b1;
                        run[i]   = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_rise = (m_rise & ~bus.evt_clr_i) | (m_acc & m_s & bus.rise_en_i & ~bus.gpio_dir_i);
            m_fall = (m_fall & ~bus.evt_clr_i) | (m_acc & ~m_s & bus.fall_en_i & ~bus.gpio_dir_i);
            m_val  = m_val ^ m_acc;
        end
        #1;
        chk("model_val",  32'(bus.gpio_in_val_o), 32'(m_val));
        chk("model_rise", 32'(bus.rise_pend_o),   32'(m_rise));
        chk("model_fall", 32'(bus.fall_pend_o),   32'(m_fall));
        chk("model_irq",  32'(bus.irq_o),         32'(|(m_rise | m_fall)));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr(input logic [NUM-1:0] m);
        bus.evt_clr_i = m;
        step(1);
        bus.evt_clr_i = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        bus.pad_in_i   = '1;
        bus.gpio_dir_i = '0;
        bus.filt_thr_i = '0;
        bus.rise_en_i  = '0;
        bus.fall_en_i  = '0;
        bus.evt_clr_i  = '0;

        // Reset with pads high, then transparent filter latency of 3
        step(3);
        chk("rst_val",  32'(bus.gpio_in_val_o), 32'h0);
        chk("rst_rise", 32'(bus.rise_pend_o),   32'h0);
        chk("rst_fall", 32'(bus.fall_pend_o),   32'h0);
        chk("rst_irq",  32'(bus.irq_o),         32'h0);
        rst = 1'b0;
        step(2);
        chk("lat_cyc2", 32'(bus.gpio_in_val_o), 32'h0);
        step(1);
        chk("lat_cyc3", 32'(bus.gpio_in_val_o), 32'hFFFF);
        bus.pad_in_i = '0;
        step(4);

        // Glitch of 3 cycles rejected at thr=3; 4 cycles accepted at cycle 6
        bus.filt_thr_i = 4'd3;
        bus.rise_en_i  = 16'h0001;
        bus.pad_in_i   = 16'h0001;
        step(3);
        bus.pad_in_i = '0;
        step(8);
        chk("glitch_val",  32'(bus.gpio_in_val_o[0]), 32'h0);
        chk("glitch_rise", 32'(bus.rise_pend_o),      32'h0);
        bus.pad_in_i = 16'h0001;
        step(4);
        bus.pad_in_i = '0;
        step(1);
        chk("thr3_cyc5", 32'(bus.gpio_in_val_o[0]), 32'h0);
        step(1);
        chk("thr3_cyc6", 32'(bus.gpio_in_val_o[0]), 32'h1);
        chk("thr3_rise", 32'(bus.rise_pend_o),      32'h0001);
        step(8);
        pulse_clr('1);
        chk("clr_all_irq", 32'(bus.irq_o), 32'h0);

        // Rising event only, irq one cycle after accept
        bus.filt_thr_i = '0;
        bus.pad_in_i   = 16'h0001;
        step(2);
        chk("evt_irq_pre", 32'(bus.irq_o), 32'h0);
        step(1);
        chk("evt_rise", 32'(bus.rise_pend_o), 32'h0001);
        chk("evt_irq",  32'(bus.irq_o),       32'h1);
        bus.pad_in_i = '0;
        step(3);
        chk("evt_fall_none", 32'(bus.fall_pend_o),   32'h0);
        chk("evt_rise_hold", 32'(bus.rise_pend_o),   32'h0001);
        chk("evt_val_low",   32'(bus.gpio_in_val_o), 32'h0);
        pulse_clr('1);

        // Output-direction pin: readback follows, no event
        bus.gpio_dir_i = 16'h0002;
        bus.rise_en_i  = 16'h0002;
        bus.pad_in_i   = 16'h0002;
        step(3);
        chk("dir_val",  32'(bus.gpio_in_val_o), 32'h0002);
        chk("dir_rise", 32'(bus.rise_pend_o),   32'h0);
        chk("dir_irq",  32'(bus.irq_o),         32'h0);
        bus.pad_in_i = '0;
        step(3);
        chk("dir_val_low", 32'(bus.gpio_in_val_o), 32'h0);
        bus.gpio_dir_i = '0;

        // Clear colliding with a new rise accept: set wins
        bus.rise_en_i = 16'h0001;
        bus.pad_in_i  = 16'h0001;
        step(3);
        bus.pad_in_i = '0;
        step(3);
        bus.pad_in_i = 16'h0001;
        step(2);
        pulse_clr(16'h0001);
        chk("collide_rise", 32'(bus.rise_pend_o[0]), 32'h1);
        step(1);
        chk("collide_hold", 32'(bus.rise_pend_o[0]), 32'h1);
        chk("collide_irq",  32'(bus.irq_o),          32'h1);
        pulse_clr(16'h0001);
        chk("clr2_rise", 32'(bus.rise_pend_o), 32'h0);
        chk("clr2_irq",  32'(bus.irq_o),       32'h0);

        // Threshold lowered below a running count: accept on the next differing cycle
        bus.fall_en_i  = 16'h0001;
        bus.filt_thr_i = 4'd7;
        bus.pad_in_i   = '0;
        step(7);
        chk("thr_hi_hold", 32'(bus.gpio_in_val_o[0]), 32'h1);
        bus.filt_thr_i = 4'd2;
        step(1);
        chk("thr_lower_val",  32'(bus.gpio_in_val_o[0]), 32'h0);
        chk("thr_lower_fall", 32'(bus.fall_pend_o),      32'h0001);
        pulse_clr('1);

        // Multi-pin pattern with a mixed direction mask
        bus.filt_thr_i = 4'd1;
        bus.rise_en_i  = '1;
        bus.fall_en_i  = '1;
        bus.gpio_dir_i = 16'h00F0;
        bus.pad_in_i   = 16'hA5C3;
        step(3);
        chk("multi_pre", 32'(bus.gpio_in_val_o), 32'h0);
        step(1);
        chk("multi_val",  32'(bus.gpio_in_val_o), 32'hA5C3);
        chk("multi_rise", 32'(bus.rise_pend_o),   32'hA503);
        chk("multi_fall", 32'(bus.fall_pend_o),   32'h0);
        bus.pad_in_i = 16'h0F0F;
        step(6);
        chk("multi2_val",  32'(bus.gpio_in_val_o), 32'h0F0F);
        chk("multi2_rise", 32'(bus.rise_pend_o),   32'hAF0F);
        chk("multi2_fall", 32'(bus.fall_pend_o),   32'hA000);
        step(4);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
